// File: rtl/simd_operand_loader.sv
// Operand staging for the SIMD packer: takes an unpack command, then builds 256-bit
// A and B operands from 64-bit beats and holds them under a valid/ready handshake.
module simd_operand_loader #(
   parameter int SIMD_WIDTH = 256,
   parameter int BUS_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_mode,
   input  logic                  cmd_hi,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BUS_WIDTH-1:0]  in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SIMD_WIDTH-1:0] A,
   output logic [SIMD_WIDTH-1:0] B,
   output logic [2:0]            data_mode,
   output logic                  hi_flag
);

   localparam int BEATS = SIMD_WIDTH / BUS_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT     = CNT_W'(BEATS - 1);
   localparam logic [2:0]       MODE_PASS_MIN = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_A = 2'd1,
      S_LOAD_B = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SIMD_WIDTH-1:0] a_q, a_d;
   logic [SIMD_WIDTH-1:0] b_q, b_d;
   logic [2:0]            mode_q, mode_d;
   logic                  hi_q, hi_d;

   logic cmd_fire;
   logic beat_fire;
   logic last_beat;
   logic pass_a;
   logic load_a;
   logic load_b;
   logic b_clear;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) state_d = S_LOAD_A;
         end
         S_LOAD_A: begin
            if (in_valid && (cnt_q == LAST_BEAT)) begin
               state_d = pass_a ? S_HOLD : S_LOAD_B;
            end
         end
         S_LOAD_B: begin
            if (in_valid && (cnt_q == LAST_BEAT)) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs from state only
   always_comb begin
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE:   cmd_ready = 1'b1;
         S_LOAD_A: in_ready  = 1'b1;
         S_LOAD_B: in_ready  = 1'b1;
         S_HOLD:   out_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- datapath control
   assign load_a    = (state_q == S_LOAD_A);
   assign load_b    = (state_q == S_LOAD_B);
   assign cmd_fire  = cmd_valid && (state_q == S_IDLE);
   assign beat_fire = in_valid && (load_a || load_b);
   assign last_beat = beat_fire && (cnt_q == LAST_BEAT);
   assign pass_a    = (mode_q >= MODE_PASS_MIN);
   // Pass-A modes never fetch B, so B is zeroed as A completes.
   assign b_clear   = load_a && last_beat && pass_a;

   always_comb begin
      cnt_d = cnt_q;
      if (cmd_fire) begin
         cnt_d = '0;
      end else if (beat_fire) begin
         cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      end
   end

   always_comb begin
      mode_d = mode_q;
      hi_d   = hi_q;
      if (cmd_fire) begin
         mode_d = cmd_mode;
         hi_d   = cmd_hi;
      end
   end

   // Each beat slot owns one BUS_WIDTH slice of A and of B.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
         logic slot_hit;
         assign slot_hit = beat_fire && (cnt_q == CNT_W'(gi));

         assign a_d[gi*BUS_WIDTH +: BUS_WIDTH] =
            (slot_hit && load_a) ? in_data : a_q[gi*BUS_WIDTH +: BUS_WIDTH];

         assign b_d[gi*BUS_WIDTH +: BUS_WIDTH] =
            (slot_hit && load_b) ? in_data :
            b_clear              ? '0      : b_q[gi*BUS_WIDTH +: BUS_WIDTH];
      end
   endgenerate

   // ---------------------------------------------------------------- datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= '0;
         hi_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         mode_q <= mode_d;
         hi_q   <= hi_d;
      end
   end

   assign A         = a_q;
   assign B         = b_q;
   assign data_mode = mode_q;
   assign hi_flag   = hi_q;

endmodule

// File: tb/tb_simd_operand_loader.sv
// Directed bench for simd_operand_loader: expected operand sets are queued when a
// command is issued and compared when out_valid is observed.
module tb_simd_operand_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_mode;
   logic         cmd_hi;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_data;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] A;
   logic [255:0] B;
   logic [2:0]   data_mode;
   logic         hi_flag;

   simd_operand_loader dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_hi    (cmd_hi),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (A),
      .B         (B),
      .data_mode (data_mode),
      .hi_flag   (hi_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] a;
      logic [255:0] b;
      logic [2:0]   mode;
      logic         hi;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   logic [63:0] bt[8];
   int          gap[8];
   int          cyc;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_op(input logic [2:0] mode, input logic hi);
      exp_t e;
      e.a    = {bt[3], bt[2], bt[1], bt[0]};
      e.b    = (mode >= 3'd5) ? 256'd0 : {bt[7], bt[6], bt[5], bt[4]};
      e.mode = mode;
      e.hi   = hi;
      sb.push_back(e);
      chk("cmd_ready_before_cmd", 256'(cmd_ready), 256'd1);
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      cmd_hi    = hi;
      cyc       = 0;
      step();
      cmd_valid = 1'b0;
      $display("cmd mode=%0d hi=%0d accepted, cycle now %0d", mode, hi, cyc);
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = bt[i];
         step();
         in_valid = 1'b0;
         repeat (gap[i]) step();
      end
   endtask

   task automatic wait_out(input int exp_cycle);
      int n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("out_valid_rise", 256'(out_valid), 256'd1);
      chk("latency_cycle", 256'(cyc), 256'(exp_cycle));
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 entries expected=1");
      end else begin
         cur = sb.pop_front();
         chk("A", A, cur.a);
         chk("B", B, cur.b);
         chk("data_mode", 256'(data_mode), 256'(cur.mode));
         chk("hi_flag", 256'(hi_flag), 256'(cur.hi));
      end
      $display("result at cycle %0d: A=%h B=%h mode=%0d hi=%0d", cyc, A, B, data_mode, hi_flag);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("idle_cmd_ready", 256'(cmd_ready), 256'd1);
      chk("idle_out_valid", 256'(out_valid), 256'd0);
      chk("idle_in_ready", 256'(in_ready), 256'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [7:0] byte_v;
      rst = 1'b1; cmd_valid = 1'b1; cmd_mode = 3'd3; cmd_hi = 1'b1;
      in_valid = 1'b1; in_data = '1; out_ready = 1'b0;
      for (int i = 0; i < 8; i++) gap[i] = 0;
      cyc = 0;

      // Reset with both input interfaces active
      step(); step();
      rst = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0;
      chk("rst_cmd_ready", 256'(cmd_ready), 256'd1);
      chk("rst_in_ready", 256'(in_ready), 256'd0);
      chk("rst_out_valid", 256'(out_valid), 256'd0);
      chk("rst_A", A, 256'd0);
      chk("rst_B", B, 256'd0);
      chk("rst_mode", 256'(data_mode), 256'd0);
      chk("rst_hi", 256'(hi_flag), 256'd0);
      $display("reset released");

      // Full back-to-back load, mode 0
      for (int i = 0; i < 8; i++) begin
         byte_v = 8'(8'h11 * (i + 1));
         bt[i]  = {8{byte_v}};
      end
      start_op(3'd0, 1'b1);
      feed(8);
      wait_out(9);
      consume();

      // Bubbles after beat 2 and beat 5, then back-pressure in HOLD
      gap[2] = 3;
      gap[5] = 2;
      start_op(3'd0, 1'b1);
      feed(8);
      wait_out(14);
      gap[2] = 0;
      gap[5] = 0;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = (i % 2 == 0);
         in_valid  = (i % 2 == 1);
         in_data   = {$urandom, $urandom};
         cmd_mode  = 3'(i + 1);
         step();
         chk("bp_out_valid", 256'(out_valid), 256'd1);
         chk("bp_cmd_ready", 256'(cmd_ready), 256'd0);
         chk("bp_in_ready", 256'(in_ready), 256'd0);
         chk("bp_A", A, cur.a);
         chk("bp_B", B, cur.b);
         chk("bp_mode", 256'(data_mode), 256'(cur.mode));
         chk("bp_hi", 256'(hi_flag), 256'(cur.hi));
         $display("backpressure cycle %0d held", i);
      end
      cmd_valid = 1'b0;
      in_valid  = 1'b0;
      consume();

      // Pass-A mode 6: four A beats only, B forced to zero
      for (int i = 0; i < 8; i++) bt[i] = {$urandom, $urandom};
      start_op(3'd6, 1'b0);
      feed(4);
      wait_out(5);
      in_valid = 1'b1;
      in_data  = bt[4];
      chk("m6_fifth_in_ready", 256'(in_ready), 256'd0);
      step();
      in_valid = 1'b0;
      chk("m6_fifth_A", A, cur.a);
      chk("m6_fifth_B", B, 256'd0);
      chk("m6_still_valid", 256'(out_valid), 256'd1);
      $display("mode 6 fifth beat refused");
      consume();

      // Reset in the middle of a mode-2 load
      for (int i = 0; i < 8; i++) bt[i] = {$urandom, $urandom};
      start_op(3'd2, 1'b1);
      feed(6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      chk("midrst_cmd_ready", 256'(cmd_ready), 256'd1);
      chk("midrst_in_ready", 256'(in_ready), 256'd0);
      chk("midrst_out_valid", 256'(out_valid), 256'd0);
      chk("midrst_A", A, 256'd0);
      chk("midrst_B", B, 256'd0);
      $display("mid-load reset done");

      // Fresh mode-1 load after the reset
      for (int i = 0; i < 8; i++) bt[i] = {$urandom, $urandom};
      start_op(3'd1, 1'b1);
      feed(8);
      wait_out(9);
      consume();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
